// File: rtl/char_serial_tx.sv
// rtl/char_serial_tx.sv - framed LSB-first serial character transmitter with pollable handshake
module char_serial_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] tx_count
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state, state_next;
    logic            load_q;
    logic [BW-1:0]   baud_cnt, baud_next;
    logic [2:0]      bit_cnt, bit_next;
    logic [7:0]      shift, shift_next;
    logic            parity, parity_next;
    logic            busy_next, done_next, line_next;
    logic [7:0]      count_next;
    logic            load_edge;
    logic            bit_end;

    assign load_edge = tx_load & ~load_q;
    assign bit_end   = (baud_cnt == BAUD_LAST);

    // State and output registers; the load history resets high so a held load is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            load_q     <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_count   <= '0;
        end else begin
            state      <= state_next;
            load_q     <= tx_load;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift      <= shift_next;
            parity     <= parity_next;
            serial_out <= line_next;
            tx_busy    <= busy_next;
            tx_done    <= done_next;
            tx_count   <= count_next;
        end
    end

    // Next-state logic; the line level is derived from the next state so the pin is registered
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift;
        parity_next = parity;
        busy_next   = tx_busy;
        done_next   = tx_done;
        count_next  = tx_count;
        line_next   = 1'b1;

        unique case (state)
            S_IDLE: begin
                if (load_edge) begin
                    shift_next  = tx_data;
                    parity_next = ^tx_data;
                    done_next   = 1'b0;
                    busy_next   = 1'b1;
                    baud_next   = '0;
                    bit_next    = '0;
                    state_next  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = S_STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    count_next = tx_count + 8'd1;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        unique case (state_next)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = shift_next[0];
            S_PARITY: line_next = parity_next;
            default:  line_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_char_serial_tx.sv
// tb/tb_char_serial_tx.sv - scoreboard bench for char_serial_tx with and without parity
module tb_char_serial_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_load, tx_load_np;
    logic       so_p, busy_p, done_p;
    logic       so_np, busy_np, done_np;
    logic [7:0] cnt_obs_p, cnt_obs_np;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] cnt_p, cnt_np;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    char_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_load(tx_load),
        .serial_out(so_p), .tx_busy(busy_p), .tx_done(done_p), .tx_count(cnt_obs_p)
    );

    char_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_load(tx_load_np),
        .serial_out(so_np), .tx_busy(busy_np), .tx_done(done_np), .tx_count(cnt_obs_np)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one frame starting at the current negedge; returns at the negedge of the first idle cycle
    task automatic frame(input logic [7:0] d, input bit pe, input bit disturb);
        logic [10:0] bits;
        int nbits;
        logic [2:0] exp, obs;
        bits = {1'b1, ^d, d, 1'b0};
        nbits = pe ? 11 : 10;
        if (!pe) bits[9] = 1'b1;
        for (int b = 0; b < nbits; b++)
            for (int c = 0; c < CPB; c++)
                exp_q.push_back({1'b0, 1'b1, bits[b]});
        tx_data = d;
        if (pe) tx_load = 1'b1; else tx_load_np = 1'b1;
        for (int i = 0; i < nbits * CPB; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            obs = pe ? {done_p, busy_p, so_p} : {done_np, busy_np, so_np};
            check(pe ? "frame_p" : "frame_np", {13'd0, obs}, {13'd0, exp});
            if (i == 0) begin
                tx_load = 1'b0;
                tx_load_np = 1'b0;
            end
            if (disturb && i == 9) begin
                tx_load = 1'b1;
                tx_data = 8'hFF;
            end
            if (disturb && i == 11) tx_load = 1'b0;
        end
        @(negedge clk);
        if (pe) cnt_p = cnt_p + 8'd1; else cnt_np = cnt_np + 8'd1;
        obs = pe ? {done_p, busy_p, so_p} : {done_np, busy_np, so_np};
        check("end_state", {13'd0, obs}, 16'b101);
        check("end_count", {8'd0, pe ? cnt_obs_p : cnt_obs_np}, {8'd0, pe ? cnt_p : cnt_np});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cnt_p = 8'd0;
        cnt_np = 8'd0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b1;
        tx_load_np = 1'b1;
        cnt_p = 8'd0;
        cnt_np = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_vals", {5'd0, done_p, busy_p, so_p, cnt_obs_p}, {5'd0, 3'b001, 8'd0});
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("held_load", {5'd0, done_p, busy_p, so_p, cnt_obs_p}, {5'd0, 3'b001, 8'd0});
        end
        tx_load = 1'b0;
        tx_load_np = 1'b0;
        @(negedge clk);

        frame(8'h41, 1'b1, 1'b0);
        frame(8'h07, 1'b1, 1'b0);
        frame(8'h07, 1'b0, 1'b0);

        frame(8'h41, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("no_replay", {13'd0, done_p, busy_p, so_p}, 16'b101);
        end
        check("no_replay_cnt", {8'd0, cnt_obs_p}, {8'd0, cnt_p});

        tx_data = 8'h41;
        tx_load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tx_load = 1'b0;
        end
        check("mid_data_busy", {15'd0, busy_p}, 16'd1);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {13'd0, done_p, busy_p, so_p}, 16'b001);
        @(negedge clk);
        reset_n = 1'b1;
        cnt_p = 8'd0;
        cnt_np = 8'd0;
        @(negedge clk);
        check("post_reset", {5'd0, done_p, busy_p, so_p, cnt_obs_p}, {5'd0, 3'b001, 8'd0});
        frame(8'h41, 1'b1, 1'b0);
        frame(8'h07, 1'b0, 1'b0);

        do_reset();
        for (int f = 0; f < 257; f++) frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        check("wrap_count", {8'd0, cnt_obs_p}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
